fft_dout_serializer: RTL and testbench
======================================

// Module: fft_dout_serializer
// PURPOSE
//  Downstream of full_parallel_fft: accepts one packed FFT result frame (2**NPOINT complex points)
//  and streams it as WIDTH-bit words, header first, toward the USB write path.
//  dout_last marks the final word, for packet-end generation. Buffers one frame.
//  Holds off the FFT with din_busy until the frame has fully drained.
// PARAMETERS
//  NPOINT  3   log2 of FFT point count; N = 2**NPOINT points per frame
//  WIDTH   16  bits per real/imag component and per output word (WIDTH >= 16)
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           reset, asynchronous, active-high
//  din_valid   in   1           FFT frame present on din_real/din_imag
//  din_busy    out  1           1 = frame not accepted this cycle
//  din_real    in   WIDTH*N     point k real at [WIDTH*k +: WIDTH]
//  din_imag    in   WIDTH*N     point k imag at [WIDTH*k +: WIDTH]
//  dout_valid  out  1           dout_data holds a word
//  dout_ready  in   1           downstream accepts word when high with dout_valid
//  dout_data   out  WIDTH       output word
//  dout_last   out  1           high with the final word of a frame
//  frame_seq   out  8           sequence number of current/next frame
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE; din_busy=0, dout_valid=0, dout_data=0,
//   dout_last=0, frame_seq=0, word counter=0, frame buffer cleared. Partial frame discarded.
//  FSM states: IDLE, HDR, DATA.
//   IDLE: din_busy=0. If din_valid: capture din_real/din_imag into buffer on this edge -> HDR.
//   HDR: dout_valid=1, dout_data={8'hA5, frame_seq} zero-extended to WIDTH.
//    On dout_valid&dout_ready -> DATA, cnt=0.
//   DATA: dout_valid=1, word index cnt in 0..2N-1: even cnt -> real[cnt/2], odd -> imag[cnt/2].
//    On transfer: cnt<2N-1 -> cnt+1. cnt=2N-1: dout_last=1 with that word.
//    The transfer then returns to IDLE and increments frame_seq (8-bit, 255 wraps to 0).
//  din_busy, dout_valid, dout_last are register outputs.
//   din_busy=1 in HDR and DATA, so IDLE lasts >=1 cycle between frames.
//  Latency: frame accepted at edge T; header valid from T+1.
//   With dout_ready held 1, last word transfers at edge T+1+2N and din_busy is low in the following cycle.
//  Handshake: valid/ready. While dout_valid=1 and dout_ready=0:
//   dout_data/dout_last stay stable and the FSM does not advance.
//   dout_valid never drops before transfer.
//  din_valid while din_busy=1: ignored; upstream must hold the frame; the buffer is never overwritten mid-frame.
//  dout_ready while dout_valid=0: no effect. Words per frame = 1 + 2N (17 for NPOINT=3).
//  Data passes bit-exact; no scaling, rounding or sign manipulation.
// TESTING (NPOINT=3, WIDTH=16)
//  T1 Reset: assert rst with random inputs.
//   -> all outputs 0 asynchronously, before next clk edge.
//  T2 Single frame, dout_ready=1: real[k]=k+1, imag[k]=-(k+1).
//   -> words A500,0001,FFFF,0002,FFFE,...,0008,FFF8; last only on 17th word;
//   -> din_busy high exactly 17 cycles; frame_seq=1 afterwards.
//  T3 Backpressure: same frame, dout_ready pattern 1,0,0,1 repeating.
//   -> identical word sequence, no loss/duplication; data and last stable during stalls.
//  T4 din_valid held high with a second frame (real[k]=0x100+k).
//   -> second frame captured only after first drains; header A501; words 0100,...
//  T5 Reset mid-frame after 5 transferred words.
//   -> dout_valid drops immediately; next frame header A500 with full 17 words.
//  T6 256 back-to-back frames.
//   -> headers A500..A5FF, then A500; frame_seq wraps to 0.

Source files
------------

// File: rtl/fft_dout_serializer.sv
// rtl/fft_dout_serializer.sv - buffers one FFT frame and streams it as a header word followed by interleaved re/im words
module fft_dout_serializer #(
  parameter int NPOINT = 3,
  parameter int WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_valid,
  output logic                           din_busy,
  input  logic [WIDTH*(2**NPOINT)-1:0]   din_real,
  input  logic [WIDTH*(2**NPOINT)-1:0]   din_imag,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [WIDTH-1:0]               dout_data,
  output logic                           dout_last,
  output logic [7:0]                     frame_seq
);

  localparam int N  = 2**NPOINT;
  localparam int CW = NPOINT + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(2*N-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [7:0]             r_seq;
  logic                   r_busy;
  logic                   r_valid;
  logic                   r_last;
  logic [WIDTH-1:0]       r_data;
  logic [WIDTH*N-1:0]     r_real;
  logic [WIDTH*N-1:0]     r_imag;

  state_t                 w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [7:0]             w_seq_nxt;
  logic                   w_busy_nxt;
  logic                   w_valid_nxt;
  logic                   w_last_nxt;
  logic [WIDTH-1:0]       w_data_nxt;
  logic                   w_capture;
  logic                   w_xfer;
  logic [CW-1:0]          w_cnt_inc;
  logic [NPOINT-1:0]      w_inc_idx;
  logic [WIDTH-1:0]       w_inc_word;

  assign w_xfer     = r_valid & dout_ready;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_inc_idx  = w_cnt_inc[CW-1:1];
  // Even word index carries the real part, odd the imaginary part of the same point.
  assign w_inc_word = w_cnt_inc[0] ? r_imag[WIDTH*w_inc_idx +: WIDTH]
                                   : r_real[WIDTH*w_inc_idx +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_seq_nxt   = r_seq;
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_data_nxt  = r_data;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (din_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HDR;
          w_busy_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_data_nxt  = WIDTH'({8'hA5, r_seq});
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_data_nxt  = r_real[WIDTH-1:0];
          w_last_nxt  = 1'b0;
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_seq_nxt   = r_seq + 8'd1;
            w_busy_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_data_nxt  = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
            w_data_nxt  = w_inc_word;
            w_last_nxt  = (w_cnt_inc == LAST_CNT);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_seq   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_real  <= '0;
      r_imag  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_seq   <= w_seq_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_data  <= w_data_nxt;
      if (w_capture) begin
        r_real <= din_real;
        r_imag <= din_imag;
      end
    end
  end

  assign din_busy   = r_busy;
  assign dout_valid = r_valid;
  assign dout_data  = r_data;
  assign dout_last  = r_last;
  assign frame_seq  = r_seq;

endmodule

// File: tb/tb_fft_dout_serializer.sv
// tb/tb_fft_dout_serializer.sv - directed bench for fft_dout_serializer with NPOINT=3, WIDTH=16
module tb_fft_dout_serializer;

  localparam int N  = 8;
  localparam int NW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_busy;
  logic [127:0]  din_real = '0;
  logic [127:0]  din_imag = '0;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [15:0]   dout_data;
  logic          dout_last;
  logic [7:0]    frame_seq;

  int            n_run  = 0;
  int            n_fail = 0;
  logic [15:0]   re [N];
  logic [15:0]   im [N];
  logic [15:0]   exp_w [NW];
  int            nbusy;

  always #5 clk = ~clk;

  fft_dout_serializer #(.NPOINT(3), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_busy(din_busy),
    .din_real(din_real), .din_imag(din_imag), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .frame_seq(frame_seq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_run++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic frame_a();
    for (int k = 0; k < N; k++) begin
      re[k] = 16'(k + 1);
      im[k] = 16'(0 - (k + 1));
    end
  endtask

  task automatic frame_b();
    for (int k = 0; k < N; k++) begin
      re[k] = 16'(16'h0100 + k);
      im[k] = 16'(16'h0200 + k);
    end
  endtask

  task automatic apply_frame();
    for (int k = 0; k < N; k++) begin
      din_real[16*k +: 16] = re[k];
      din_imag[16*k +: 16] = im[k];
    end
  endtask

  task automatic build_exp(input logic [7:0] seq);
    exp_w[0] = {8'hA5, seq};
    for (int k = 0; k < N; k++) begin
      exp_w[1 + 2*k] = re[k];
      exp_w[2 + 2*k] = im[k];
    end
  endtask

  // Called at a negedge right after the frame was accepted; returns at the negedge after the last transfer.
  task automatic drain(input bit pat, input int budget, output int busy_cnt);
    int   idx = 0;
    int   cyc = 0;
    bit   rdy;
    bit   stalled = 1'b0;
    logic [15:0] held_d = '0;
    logic        held_l = 1'b0;
    busy_cnt = 0;
    while (idx < NW && cyc < budget) begin
      rdy = pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      dout_ready = rdy;
      if (din_busy) busy_cnt++;
      if (stalled) begin
        chk("stall_valid", 32'(dout_valid), 32'd1);
        chk("stall_data", 32'(dout_data), 32'(held_d));
        chk("stall_last", 32'(dout_last), 32'(held_l));
      end
      if (dout_valid) begin
        if (rdy) begin
          chk($sformatf("word%0d", idx), 32'(dout_data), 32'(exp_w[idx]));
          chk($sformatf("last%0d", idx), 32'(dout_last), 32'(idx == NW - 1));
          idx++;
          stalled = 1'b0;
        end else begin
          held_d  = dout_data;
          held_l  = dout_last;
          stalled = 1'b1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    chk("drain_count", 32'(idx), 32'(NW));
  endtask

  initial begin
    // T1: asynchronous reset with junk on the inputs
    din_valid  = 1'b1;
    din_real   = {$urandom, $urandom, $urandom, $urandom};
    din_imag   = {$urandom, $urandom, $urandom, $urandom};
    dout_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(din_busy), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_data", 32'(dout_data), 32'd0);
    chk("rst_last", 32'(dout_last), 32'd0);
    chk("rst_seq", 32'(frame_seq), 32'd0);
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(dout_valid), 32'd0);

    // T2: single frame, ready held high
    frame_a();
    apply_frame();
    build_exp(8'h00);
    chk("t2_busy_before", 32'(din_busy), 32'd0);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("t2_hdr", 32'(dout_data), 32'h0000A500);
    drain(1'b0, 40, nbusy);
    chk("t2_busy_cycles", 32'(nbusy), 32'd17);
    chk("t2_busy_after", 32'(din_busy), 32'd0);
    chk("t2_valid_after", 32'(dout_valid), 32'd0);
    chk("t2_seq", 32'(frame_seq), 32'd1);

    // T3: backpressure 1,0,0,1
    build_exp(8'h01);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    chk("t3_hdr", 32'(dout_data), 32'h0000A501);
    drain(1'b1, 80, nbusy);
    chk("t3_seq", 32'(frame_seq), 32'd2);

    // T4: din_valid held while a different frame waits upstream
    dout_ready = 1'b1;
    build_exp(8'h02);
    din_valid = 1'b1;
    @(negedge clk);
    frame_b();
    apply_frame();
    drain(1'b0, 40, nbusy);
    chk("t4_idle_gap", 32'(din_busy), 32'd0);
    build_exp(8'h03);
    @(negedge clk);
    din_valid = 1'b0;
    chk("t4_hdr2", 32'(dout_data), 32'h0000A503);
    drain(1'b0, 40, nbusy);
    chk("t4_seq", 32'(frame_seq), 32'd4);

    // T5: reset after 5 transferred words
    frame_a();
    apply_frame();
    build_exp(8'h04);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_pre%0d", i), 32'(dout_data), 32'(exp_w[i]));
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(dout_valid), 32'd0);
    chk("t5_busy", 32'(din_busy), 32'd0);
    chk("t5_seq", 32'(frame_seq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    build_exp(8'h00);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    drain(1'b0, 40, nbusy);

    // T6: 256 back-to-back frames then wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b1;
    for (int f = 0; f < 256; f++) begin
      build_exp(8'(f));
      @(negedge clk);
      drain(1'b0, 40, nbusy);
    end
    chk("t6_seq_wrap", 32'(frame_seq), 32'd0);
    build_exp(8'h00);
    @(negedge clk);
    din_valid = 1'b0;
    chk("t6_hdr_wrap", 32'(dout_data), 32'h0000A500);
    drain(1'b0, 40, nbusy);
    chk("t6_seq_end", 32'(frame_seq), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
